button_reader: RTL and testbench

Input-side companion to the LED blink/counter path. It samples the raw low-active push-button, synchronises and debounces it, and classifies presses. It publishes a debounced level, one-cycle press/release/long-press ticks, and a wrapping press counter for downstream logic such as LED pattern selection. It sits in the `clk` domain next to `ResetGeneration` and takes its reset from there.

---
 rtl/button_reader_pkg.sv | 21 ++
 rtl/button_sync.sv | 23 ++
 rtl/button_reader.sv | 116 +++++++++++
 tb/tb_button_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/button_reader_pkg.sv
// rtl/button_reader_pkg.sv - shared state encoding and counter sizing for button_reader
package button_reader_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_QUAL   = 2'd1,
    HELD         = 2'd2,
    RELEASE_QUAL = 2'd3
  } btn_state_t;

  // Bits needed to hold values 0..n, never less than 1.
  function automatic int regsize(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) <= n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchroniser for asynchronous pad inputs, optional inversion
module button_sync #(
  parameter bit Invert = 1'b0
) (
  input  logic clk,
  input  logic rstx,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din ^ Invert;
      dout <= meta;
    end
  end

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounces a low-active push-button and classifies press, release
// and long-press events, with a wrapping press counter.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int DebounceCycles  = 240000,
  parameter int LongPressCycles = 24000000,
  parameter int CountWidth      = 8
) (
  input  logic                  clk,
  input  logic                  rstx,
  input  logic                  btnx,
  output logic                  pressed,
  output logic                  press_tick,
  output logic                  release_tick,
  output logic                  long_tick,
  output logic [CountWidth-1:0] press_count
);

  localparam int DebW  = regsize(DebounceCycles);
  localparam int HoldW = regsize(LongPressCycles);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LongPressCycles - 1);

  if (DebounceCycles < 1) begin : g_bad_debounce
    $error("button_reader: DebounceCycles must be >= 1");
  end
  if (LongPressCycles <= DebounceCycles) begin : g_bad_long
    $error("button_reader: LongPressCycles must exceed DebounceCycles");
  end

  logic             btn_s;
  btn_state_t       state;
  logic [DebW-1:0]  deb_cnt;
  logic [HoldW-1:0] hold_cnt;
  logic             hold_done;

  button_sync #(.Invert(1'b1)) u_sync (
    .clk  (clk),
    .rstx (rstx),
    .din  (btnx),
    .dout (btn_s)
  );

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state        <= IDLE;
      deb_cnt      <= '0;
      hold_cnt     <= '0;
      hold_done    <= 1'b0;
      pressed      <= 1'b0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      press_count  <= '0;
    end else begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;

      case (state)
        IDLE: begin
          if (btn_s) begin
            state   <= PRESS_QUAL;
            deb_cnt <= '0;
          end
        end
        PRESS_QUAL: begin
          if (!btn_s) begin
            state <= IDLE;
          end else if (deb_cnt == DebLast) begin
            state       <= HELD;
            pressed     <= 1'b1;
            press_tick  <= 1'b1;
            press_count <= press_count + 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state   <= RELEASE_QUAL;
            deb_cnt <= '0;
          end
        end
        RELEASE_QUAL: begin
          if (btn_s) begin
            state <= HELD;
          end else if (deb_cnt == DebLast) begin
            state        <= IDLE;
            pressed      <= 1'b0;
            release_tick <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Hold timer keeps running through release qualification so a long press
      // can still complete on the same edge as the release.
      if (state == PRESS_QUAL && btn_s && deb_cnt == DebLast) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (state == HELD || state == RELEASE_QUAL) begin
        if (hold_cnt != HoldLast) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else if (!hold_done) begin
          hold_done <= 1'b1;
          long_tick <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - directed self-checking bench for button_reader
module tb_button_reader;

  logic       clk;
  logic       rstx;
  logic       btnx;
  logic       pressed;
  logic       press_tick;
  logic       release_tick;
  logic       long_tick;
  logic [7:0] press_count;

  int n_tests = 0;
  int n_fail  = 0;
  int n_press = 0;
  int n_rel   = 0;
  int n_long  = 0;
  int n_drop  = 0;

  button_reader #(
    .DebounceCycles  (4),
    .LongPressCycles (20),
    .CountWidth      (8)
  ) dut (
    .clk          (clk),
    .rstx         (rstx),
    .btnx         (btnx),
    .pressed      (pressed),
    .press_tick   (press_tick),
    .release_tick (release_tick),
    .long_tick    (long_tick),
    .press_count  (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (press_tick)   n_press++;
    if (release_tick) n_rel++;
    if (long_tick)    n_long++;
    if (!pressed)     n_drop++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_long = 0; n_drop = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rstx = 1'b0;
    step(2);
    @(negedge clk) rstx = 1'b1;
    step(2);
  endtask

  initial begin
    logic [7:0] cnt_snap;
    logic       found;

    rstx = 1'b0;
    btnx = 1'b1;
    step(3);
    check("reset_pressed", pressed, 0);
    check("reset_ticks", {press_tick, release_tick, long_tick}, 0);
    check("reset_count", press_count, 0);
    @(negedge clk) rstx = 1'b1;
    step(3);

    // Bounce rejection: 3 low / 2 high, three times.
    clear_counts();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk) btnx = 1'b0;
      step(3);
      @(negedge clk) btnx = 1'b1;
      step(2);
    end
    step(10);
    check("bounce_press_ticks", n_press, 0);
    check("bounce_rel_ticks", n_rel, 0);
    check("bounce_pressed", pressed, 0);
    check("bounce_count", press_count, 0);

    // Clean press: 10 cycles low; press tick after E0+6, release after R0+6.
    clear_counts();
    @(negedge clk) btnx = 1'b0;
    step(6);
    check("clean_press_early", {pressed, press_tick}, 2'b00);
    step(1);
    check("clean_press_tick", {pressed, press_tick}, 2'b11);
    check("clean_count", press_count, 1);
    step(1);
    check("clean_tick_drop", press_tick, 0);
    step(2);
    @(negedge clk) btnx = 1'b1;
    step(6);
    check("clean_rel_early", {pressed, release_tick}, 2'b10);
    step(1);
    check("clean_rel_tick", {pressed, release_tick}, 2'b01);
    step(5);
    check("clean_press_once", n_press, 1);
    check("clean_rel_once", n_rel, 1);
    check("clean_no_long", n_long, 0);

    // Long press: 40 cycles low, long tick after E0+26.
    @(negedge clk) btnx = 1'b0;
    step(7);
    check("long_pressed", pressed, 1);
    clear_counts();
    step(19);
    check("long_early", {long_tick, 5'(n_long)}, 0);
    step(1);
    check("long_tick", long_tick, 1);
    step(1);
    check("long_tick_drop", long_tick, 0);
    step(12);
    check("long_once", n_long, 1);
    check("long_held", n_drop, 0);
    check("long_no_release", n_rel, 0);
    @(negedge clk) btnx = 1'b1;
    step(10);
    check("long_released", pressed, 0);

    // Release glitch while held.
    @(negedge clk) btnx = 1'b0;
    step(10);
    cnt_snap = press_count;
    check("glitch_count_pre", cnt_snap, 3);
    clear_counts();
    @(negedge clk) btnx = 1'b1;
    step(2);
    @(negedge clk) btnx = 1'b0;
    step(10);
    check("glitch_pressed", pressed, 1);
    check("glitch_no_drop", n_drop, 0);
    check("glitch_no_release", n_rel, 0);
    check("glitch_count", press_count, cnt_snap);
    @(negedge clk) btnx = 1'b1;
    step(10);

    // Wrap: 256 presses from a fresh reset.
    do_reset();
    clear_counts();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk) btnx = 1'b0;
      step(8);
      @(negedge clk) btnx = 1'b1;
      step(8);
      if (i == 254) check("wrap_count_255", press_count, 255);
    end
    check("wrap_count_0", press_count, 0);
    check("wrap_ticks", n_press, 256);

    // Reset while held, then re-detection of the still-held button.
    @(negedge clk) btnx = 1'b0;
    step(10);
    check("rst_pre_count", press_count, 1);
    clear_counts();
    @(negedge clk) rstx = 1'b0;
    #1;
    check("rst_async_pressed", pressed, 0);
    check("rst_async_count", press_count, 0);
    check("rst_async_ticks", {press_tick, release_tick, long_tick}, 0);
    step(3);
    check("rst_no_release", n_rel, 0);
    @(negedge clk) rstx = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      if (press_tick) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_repress", found, 1);
    check("rst_repress_count", press_count, 1);
    @(negedge clk) btnx = 1'b1;
    step(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
